// File: rtl/hc595_rx.sv
// Receiver for the two-chip 74HC595 serial display link: deserializes 16-bit frames into sel/seg.
// Optional HC595_RX_Q7S_EN adds a registered cascade output q7s (sr[15]).
module hc595_rx #(
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned ERR_CNT_W   = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 ds,
   input  logic                 shcp,
   input  logic                 stcp,
   output logic [7:0]           sel_o,
   output logic [7:0]           seg_o,
   output logic                 frame_vld,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 link_up
`ifdef HC595_RX_Q7S_EN
   ,
   output logic                 q7s
`endif
);

   localparam int unsigned     IdleW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT_CYC);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYC - 1);
   localparam logic [4:0]       BitMax   = 5'd31;
   localparam logic [4:0]       FrameLen = 5'd16;

   // Index 0 = s1, 1 = s2, 2 = s3 (history); equal depth keeps ds aligned to shcp.
   logic [2:0] ds_sync_q;
   logic [2:0] shcp_sync_q;
   logic [2:0] stcp_sync_q;

   logic ds_s2;
   logic sh_rise;
   logic st_rise;

   logic [15:0]          sr_q, sr_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic                 synced_q, synced_d;
   logic [7:0]           sel_q, sel_d;
   logic [7:0]           seg_q, seg_d;
   logic                 vld_q, vld_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [IdleW-1:0]     idle_q, idle_d;
   logic                 link_q, link_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ds_sync_q   <= '0;
         shcp_sync_q <= '0;
         stcp_sync_q <= '0;
      end else begin
         ds_sync_q   <= {ds_sync_q[1:0], ds};
         shcp_sync_q <= {shcp_sync_q[1:0], shcp};
         stcp_sync_q <= {stcp_sync_q[1:0], stcp};
      end
   end

   assign ds_s2   = ds_sync_q[1];
   assign sh_rise = shcp_sync_q[1] & ~shcp_sync_q[2];
   assign st_rise = stcp_sync_q[1] & ~stcp_sync_q[2];

   // The ds history flop exists only to keep all three pipelines identical.
   logic unused_ds_s3;
   assign unused_ds_s3 = ds_sync_q[2];

   always_comb begin
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      synced_d  = synced_q;
      sel_d     = sel_q;
      seg_d     = seg_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      idle_d    = idle_q;
      link_d    = link_q;

      if (sh_rise) begin
         sr_d = {sr_q[14:0], ds_s2};
         if (bit_cnt_q != BitMax) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
         end
      end

      // Latch decisions use the pre-shift sr/bit_cnt; a coincident bit starts the next frame.
      if (st_rise) begin
         bit_cnt_d = sh_rise ? 5'd1 : 5'd0;
         if (!synced_q) begin
            synced_d = 1'b1;
         end else if (bit_cnt_q == FrameLen) begin
            seg_d = sr_q[15:8];
            sel_d = sr_q[7:0];
            vld_d = 1'b1;
         end else begin
            err_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
         end
      end

      if (sh_rise) begin
         idle_d = '0;
         link_d = 1'b1;
      end else if (idle_q != IdleMax) begin
         idle_d = idle_q + IdleW'(1);
         // Timeout fires once on reaching the limit; the next stcp becomes a resync.
         if (idle_q == IdleLast) begin
            link_d   = 1'b0;
            synced_d = 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sr_q      <= '0;
         bit_cnt_q <= '0;
         synced_q  <= 1'b0;
         sel_q     <= 8'hFF;
         seg_q     <= 8'hFF;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         idle_q    <= '0;
         link_q    <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         synced_q  <= synced_d;
         sel_q     <= sel_d;
         seg_q     <= seg_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         idle_q    <= idle_d;
         link_q    <= link_d;
      end
   end

   assign sel_o     = sel_q;
   assign seg_o     = seg_q;
   assign frame_vld = vld_q;
   assign frame_err = err_q;
   assign err_cnt   = err_cnt_q;
   assign link_up   = link_q;

`ifdef HC595_RX_Q7S_EN
   logic q7s_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         q7s_q <= 1'b0;
      end else begin
         q7s_q <= sr_q[15];
      end
   end

   assign q7s = q7s_q;
`endif

endmodule

// File: tb/tb_hc595_rx.sv
// Randomized bench for hc595_rx: a frame-level model (bit queue + event timeline) checked every cycle.
// Directed phases cover resync, short/long frames, saturation, timeout, coincident edges and reset.
module tb_hc595_rx;

   localparam int unsigned TimeoutCyc = 64;
   localparam int          Lat        = 3;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       ds = 1'b0;
   logic       shcp = 1'b0;
   logic       stcp = 1'b0;
   logic [7:0] sel_o;
   logic [7:0] seg_o;
   logic       frame_vld;
   logic       frame_err;
   logic [7:0] err_cnt;
   logic       link_up;
`ifdef HC595_RX_Q7S_EN
   logic       q7s;
`endif

   hc595_rx #(
      .TIMEOUT_CYC(TimeoutCyc),
      .ERR_CNT_W  (8)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .ds       (ds),
      .shcp     (shcp),
      .stcp     (stcp),
      .sel_o    (sel_o),
      .seg_o    (seg_o),
      .frame_vld(frame_vld),
      .frame_err(frame_err),
      .err_cnt  (err_cnt),
      .link_up  (link_up)
`ifdef HC595_RX_Q7S_EN
      ,
      .q7s      (q7s)
`endif
   );

   always #10 sys_clk = ~sys_clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int vld_cnt = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Pin events, each taking effect Lat edges after the pin changes.
   typedef struct {
      int at;
      bit st;
      bit b;
   } ev_t;
   ev_t evq[$];

   // Model state, owned by the compare process.
   bit         bq[$];
   bit         m_synced;
   bit         m_seen;
   int         m_last_sh;
   logic [7:0] m_sel, m_seg, m_errcnt;
   logic       m_vld, m_err;

   always @(negedge sys_clk) begin
      m_vld = 1'b0;
      m_err = 1'b0;
      if (!sys_rst_n) begin
         evq.delete();
         bq.delete();
         m_synced  = 1'b0;
         m_seen    = 1'b0;
         m_last_sh = cyc + 1;
         m_sel     = 8'hFF;
         m_seg     = 8'hFF;
         m_errcnt  = 8'h00;
      end else begin
         while (evq.size() > 0 && evq[0].at <= cyc) begin
            ev_t e;
            e = evq.pop_front();
            if (e.st) begin
               if (!m_synced) begin
                  m_synced = 1'b1;
               end else if (bq.size() == 16) begin
                  logic [15:0] v;
                  v = '0;
                  foreach (bq[i]) v = {v[14:0], bq[i]};
                  m_seg = v[15:8];
                  m_sel = v[7:0];
                  m_vld = 1'b1;
               end else begin
                  m_err = 1'b1;
                  if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
               end
               bq.delete();
            end else begin
               bq.push_back(e.b);
               m_seen    = 1'b1;
               m_last_sh = cyc;
            end
         end
         if (cyc - m_last_sh == int'(TimeoutCyc)) m_synced = 1'b0;
      end
      if (frame_vld === 1'b1) vld_cnt++;
      chk("sel_o", 32'(sel_o), 32'(m_sel));
      chk("seg_o", 32'(seg_o), 32'(m_seg));
      chk("frame_vld", 32'(frame_vld), 32'(m_vld));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
      chk("link_up", 32'(link_up),
          32'(m_seen && sys_rst_n && (cyc - m_last_sh < int'(TimeoutCyc))));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic push_ev(input bit st, input bit b);
      ev_t e;
      e.at = cyc + Lat;
      e.st = st;
      e.b  = b;
      evq.push_back(e);
   endtask

   task automatic send_bit(input bit b);
      ds = b;
      tick(3);
      shcp = 1'b1;
      push_ev(1'b0, b);
      tick(3);
      shcp = 1'b0;
   endtask

   // Sends the top n bits of {seg, sel}, MSB first; bits past 16 are random filler.
   task automatic send_bits(input logic [15:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         send_bit(i < 16 ? data[15-i] : 1'($urandom));
      end
   endtask

   task automatic latch();
      stcp = 1'b1;
      push_ev(1'b1, 1'b0);
      tick(3);
      stcp = 1'b0;
      tick(3);
   endtask

   task automatic latch_with_bit(input bit b);
      ds = b;
      tick(3);
      stcp = 1'b1;
      shcp = 1'b1;
      push_ev(1'b1, 1'b0);
      push_ev(1'b0, b);
      tick(3);
      stcp = 1'b0;
      shcp = 1'b0;
      tick(3);
   endtask

   task automatic send_frame(input logic [7:0] sel, input logic [7:0] seg, input int n);
      send_bits({seg, sel}, n);
      latch();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      tick(5);
      chk("rst_sel", 32'(sel_o), 32'hFF);
      chk("rst_seg", 32'(seg_o), 32'hFF);
      chk("rst_link", 32'(link_up), 32'h0);
      chk("rst_errcnt", 32'(err_cnt), 32'h0);
      sys_rst_n = 1'b1;
      tick(2);

      // Zero-length frame after reset only resyncs.
      latch();
      chk("resync_vld", 32'(vld_cnt), 32'd0);
      for (int i = 0; i < 3; i++) send_frame(8'hFE, 8'hC0, 16);
      chk("t1_vlds", 32'(vld_cnt), 32'd3);
      chk("t1_sel", 32'(sel_o), 32'hFE);
      chk("t1_seg", 32'(seg_o), 32'hC0);
      chk("t1_err", 32'(err_cnt), 32'h0);

      // Short frame, then recovery.
      send_frame(8'hFD, 8'hF9, 15);
      chk("t2_err", 32'(err_cnt), 32'h1);
      chk("t2_sel_hold", 32'(sel_o), 32'hFE);
      chk("t2_seg_hold", 32'(seg_o), 32'hC0);
      send_frame(8'hFD, 8'hF9, 16);
      chk("t2_sel", 32'(sel_o), 32'hFD);
      chk("t2_seg", 32'(seg_o), 32'hF9);

      // Link timeout and resync.
      chk("t4_link_before", 32'(link_up), 32'h1);
      tick(TimeoutCyc + 8);
      chk("t4_link_down", 32'(link_up), 32'h0);
      v0 = vld_cnt;
      send_bit(1'b0);
      chk("t4_link_up", 32'(link_up), 32'h1);
      send_bits(16'h2A55, 15);
      latch();
      chk("t4_resync_vld", 32'(vld_cnt), 32'(v0));
      chk("t4_resync_err", 32'(err_cnt), 32'h1);
      send_frame(8'h7F, 8'h92, 16);
      chk("t4_sel", 32'(sel_o), 32'h7F);
      chk("t4_seg", 32'(seg_o), 32'h92);

      // Coincident shcp/stcp: latch pre-shift frame, new bit opens the next.
      send_bits({8'h86, 8'hFB}, 16);
      latch_with_bit(1'b1);
      chk("t5_sel", 32'(sel_o), 32'hFB);
      chk("t5_seg", 32'(seg_o), 32'h86);
      send_bits(16'hA4F7 << 1, 15);
      latch();
      chk("t5_sel2", 32'(sel_o), 32'hF7);
      chk("t5_seg2", 32'(seg_o), 32'hA4);
      chk("t5_err", 32'(err_cnt), 32'h1);

      // Random frames, occasionally the wrong length, with random gaps.
      for (int i = 0; i < 30; i++) begin
         int n;
         n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 20)) : 16;
         send_frame(8'($urandom), 8'($urandom), n);
         tick($urandom_range(0, 20));
      end

      // Error counter saturation.
      for (int i = 0; i < 300; i++) send_frame(8'($urandom), 8'($urandom), 17);
      chk("t3_sat", 32'(err_cnt), 32'hFF);

      // Reset in the middle of a frame.
      send_bits(16'h5A5A, 8);
      tick(2);
      sys_rst_n = 1'b0;
      #1;
      chk("t6_sel", 32'(sel_o), 32'hFF);
      chk("t6_seg", 32'(seg_o), 32'hFF);
      chk("t6_err", 32'(err_cnt), 32'h0);
      chk("t6_link", 32'(link_up), 32'h0);
      tick(3);
      sys_rst_n = 1'b1;
      tick(2);
      latch();
      send_frame(8'h3C, 8'hA5, 16);
      chk("t6_sel2", 32'(sel_o), 32'h3C);
      chk("t6_seg2", 32'(seg_o), 32'hA5);
      chk("t6_err2", 32'(err_cnt), 32'h0);

      tick(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
